// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter with runtime parity/stop config; define UART_TX_BREAK_EN for line-break support
module uart_tx_fifo #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              parity_en,
   input  logic              even_parity,
   input  logic              two_stop,
`ifdef UART_TX_BREAK_EN
   input  logic              brk,
`endif
   output logic              tx,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              fifo_empty
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int NW = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
`ifdef UART_TX_BREAK_EN
      S_BREAK,
      S_BRK_END,
`endif
      S_STOP
   } state_t;

   state_t              state;
   state_t              state_n;
   state_t              frame_next;

   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic                push;
   logic                pop;

   logic [DATA_W-1:0]   data_q;
   logic                par_q;
   logic                par_en_q;
   logic                two_q;

   logic [BW-1:0]       baud_cnt;
   logic [NW-1:0]       bit_cnt;
   logic                cell_end;
   logic                last_stop;
   logic                tx_q;
   logic                tx_next;

   assign fifo_empty = (count == '0);
   assign wr_ready   = (count != CW'(FIFO_DEPTH));
   assign push       = wr_valid && wr_ready;
   // START is only ever entered through a pop of the head word
   assign pop        = (state_n == S_START) && (state != S_START);
   assign cell_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
   assign last_stop  = cell_end && (bit_cnt == {{(NW-1){1'b0}}, two_q});
   assign tx         = tx_q;

   // Where to go at a frame boundary: break request first, then queued data
`ifdef UART_TX_BREAK_EN
   assign frame_next = brk ? S_BREAK : (!fifo_empty ? S_START : S_IDLE);
`else
   assign frame_next = !fifo_empty ? S_START : S_IDLE;
`endif

   // FIFO storage write port (no reset needed, validity tracked by count)
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers/count and per-frame latch of data and line config
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_q   <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         two_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_q   <= mem[rd_ptr];
            par_en_q <= parity_en;
            two_q    <= two_stop;
            par_q    <= even_parity ? (^mem[rd_ptr]) : (~^mem[rd_ptr]);
         end else if (state == S_DATA && cell_end) begin
            data_q <= data_q >> 1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // State register, bit-cell timing counters and registered serial line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_q     <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state <= state_n;
         tx_q  <= tx_next;
         if (state_n != state || cell_end || state == S_IDLE) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
         if (state_n != state) begin
            bit_cnt <= '0;
         end else if (cell_end) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // Next-state decode: advance one bit cell at a time through the frame
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (brk) begin
               state_n = S_BREAK;
            end else
`endif
            if (!fifo_empty) begin
               state_n = S_START;
            end
         end
         S_START: begin
            if (cell_end) state_n = S_DATA;
         end
         S_DATA: begin
            if (cell_end && bit_cnt == NW'(DATA_W - 1)) begin
               state_n = par_en_q ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (cell_end) state_n = S_STOP;
         end
         S_STOP: begin
            if (last_stop) state_n = frame_next;
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            if (!brk) state_n = S_BRK_END;
         end
         S_BRK_END: begin
            if (cell_end) state_n = frame_next;
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

   // Output decode: line level for the coming cycle, busy and done flags
   always_comb begin
      tx_next = 1'b1;
      case (state_n)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = (state == S_DATA && cell_end) ? data_q[1] : data_q[0];
         S_PARITY: tx_next = par_q;
`ifdef UART_TX_BREAK_EN
         S_BREAK:  tx_next = 1'b0;
`endif
         default:  tx_next = 1'b1;
      endcase
      tx_busy = (state != S_IDLE);
      tx_done = (state == S_STOP) && last_stop;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
   localparam int DW  = 8;
   localparam int CPB = 4;
   localparam int FD  = 4;

   logic          clk;
   logic          rst;
   logic [DW-1:0] wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic          parity_en;
   logic          even_parity;
   logic          two_stop;
   logic          tx;
   logic          tx_busy;
   logic          tx_done;
   logic          fifo_empty;
`ifdef UART_TX_BREAK_EN
   logic          brk;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_fifo #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
      .clk(clk),
      .rst(rst),
      .wr_data(wr_data),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .parity_en(parity_en),
      .even_parity(even_parity),
      .two_stop(two_stop),
`ifdef UART_TX_BREAK_EN
      .brk(brk),
`endif
      .tx(tx),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .fifo_empty(fifo_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queued words, plus the expected line level for every remaining cycle
   // of the frame in flight (0/1 = frame cell, 2 = post-break high cell).
   logic [DW-1:0] m_fifo[$];
   int            m_line[$];
   bit            m_brk = 1'b0;
   bit            m_push;
   logic [DW-1:0] m_word;

   task automatic build_frame(input logic [DW-1:0] w);
      int cells[$];
      cells.push_back(0);
      for (int i = 0; i < DW; i++) cells.push_back(int'(w[i]));
      if (parity_en) cells.push_back(even_parity ? int'(^w) : int'(~^w));
      cells.push_back(1);
      if (two_stop) cells.push_back(1);
      foreach (cells[k]) repeat (CPB) m_line.push_back(cells[k]);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fifo.delete();
         m_line.delete();
         m_brk = 1'b0;
      end else begin
         m_push = wr_valid && (m_fifo.size() < FD);
         m_word = wr_data;
         if (m_line.size() > 0) void'(m_line.pop_front());
         if (m_line.size() == 0) begin
`ifdef UART_TX_BREAK_EN
            if (m_brk) begin
               if (!brk) begin
                  m_brk = 1'b0;
                  repeat (CPB) m_line.push_back(2);
               end
            end else if (brk) begin
               m_brk = 1'b1;
            end else
`endif
            if (m_fifo.size() > 0) build_frame(m_fifo.pop_front());
         end
         if (m_push) m_fifo.push_back(m_word);
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic e_tx, e_busy, e_done;
      e_busy = (m_line.size() > 0) || m_brk;
      e_tx   = m_brk ? 1'b0 : ((m_line.size() == 0) ? 1'b1 : (m_line[0] != 0));
      e_done = !m_brk && (m_line.size() == 1) && (m_line[0] != 2);
      check("tx", tx, e_tx);
      check("tx_busy", tx_busy, e_busy);
      check("tx_done", tx_done, e_done);
      check("wr_ready", wr_ready, m_fifo.size() != FD);
      check("fifo_empty", fifo_empty, m_fifo.size() == 0);
   end

   // Measurement monitor for the hand-computed checks
   int busy_cyc, done_cnt, rises;
   int trace[$];
   bit prev_busy = 1'b0;
   always @(negedge clk) begin
      if (tx_busy) begin
         busy_cyc++;
         trace.push_back(int'(tx));
      end
      if (tx_done) done_cnt++;
      if (tx_busy && !prev_busy) rises++;
      prev_busy = tx_busy;
   end

   task automatic clear_meas();
      busy_cyc = 0;
      done_cnt = 0;
      rises    = 0;
      trace.delete();
   endtask

   task automatic push(input logic [DW-1:0] w);
      wr_data  = w;
      wr_valid = 1'b1;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (!tx_busy && fifo_empty) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, ok, 1'b1);
   endtask

   initial begin
      logic [9:0] exp1;
      logic [DW-1:0] words[6];
      bit acc, saw_full, ok;
      int guard, ones;

      rst = 1'b1;
      wr_data = '0;
      wr_valid = 1'b0;
      parity_en = 1'b0;
      even_parity = 1'b0;
      two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      check("rst_ready", wr_ready, 1'b1);
      check("rst_empty", fifo_empty, 1'b1);
      rst = 1'b0;

      // 1: 0xA5, no parity, one stop
      clear_meas();
      push(8'hA5);
      wait_idle("t1_timeout");
      exp1 = 10'b1101001010;
      check("t1_busy_len", busy_cyc, 40);
      check("t1_done_cnt", done_cnt, 1);
      for (int i = 0; i < 10; i++) check("t1_cell", trace[4*i+1], int'(exp1[i]));

      // 2: 0x07 with even then odd parity
      parity_en = 1'b1;
      even_parity = 1'b1;
      clear_meas();
      push(8'h07);
      wait_idle("t2e_timeout");
      check("t2e_len", busy_cyc, 44);
      check("t2e_parity", trace[37], 1);
      even_parity = 1'b0;
      clear_meas();
      push(8'h07);
      wait_idle("t2o_timeout");
      check("t2o_len", busy_cyc, 44);
      check("t2o_parity", trace[37], 0);
      parity_en = 1'b0;

      // 3: fill the FIFO while a frame runs
      words = '{8'h3A, 8'hC4, 8'h01, 8'h80, 8'h5F, 8'hE2};
      clear_meas();
      saw_full = 1'b0;
      push(8'h11);
      wr_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wr_data = words[k];
         guard = 0;
         do begin
            acc = wr_ready;
            if (!acc) saw_full = 1'b1;
            @(posedge clk);
            #1;
            guard++;
         end while (!acc && guard < 500);
      end
      wr_valid = 1'b0;
      wait_idle("t3_timeout");
      check("t3_saw_full", saw_full, 1'b1);
      check("t3_done_cnt", done_cnt, 7);
      check("t3_busy_len", busy_cyc, 280);
      check("t3_busy_rises", rises, 1);

      // 4: two stop bits, config toggled mid-frame
      two_stop = 1'b1;
      clear_meas();
      push(8'hFF);
      repeat (10) @(posedge clk);
      #1;
      two_stop = 1'b0;
      wait_idle("t4_timeout");
      check("t4_len", busy_cyc, 44);
      ones = 0;
      for (int i = 36; i < 44; i++) ones += trace[i];
      check("t4_stop_high", ones, 8);

      // 5: asynchronous reset during data bit 3
      clear_meas();
      push(8'h3C);
      push(8'h5A);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (busy_cyc >= 18) begin
            ok = 1'b1;
            break;
         end
      end
      check("t5_reach", ok, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("t5_tx", tx, 1'b1);
      check("t5_busy", tx_busy, 1'b0);
      check("t5_empty", fifo_empty, 1'b1);
      check("t5_ready", wr_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      clear_meas();
      push(8'h96);
      wait_idle("t5_timeout");
      check("t5_len", busy_cyc, 40);
      check("t5_done_cnt", done_cnt, 1);

`ifdef UART_TX_BREAK_EN
      // 6: break with a word queued
      clear_meas();
      brk = 1'b1;
      push(8'h33);
      repeat (29) @(posedge clk);
      #1;
      brk = 1'b0;
      wait_idle("t6_timeout");
      check("t6_len", busy_cyc, 74);
      check("t6_low_end", trace[29], 0);
      check("t6_high_start", trace[30], 1);
      check("t6_high_end", trace[33], 1);
      check("t6_start_bit", trace[34], 0);
      check("t6_done_cnt", done_cnt, 1);
`endif

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
